serial_addsub: RTL and testbench

//  Multi-cycle, digit-serial N-bit adder/subtractor. Processes CHUNK bits per clock with

---
 rtl/serial_addsub.sv | 143 ++++++++++++++
 tb/tb_serial_addsub.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// Digit-serial N-bit adder/subtractor: CHUNK bits per clock, LSB chunk first,
// with start/busy/done handshake and NZCV flags registered on completion.
module serial_addsub #(
   parameter int unsigned N     = 8,
   parameter int unsigned CHUNK = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         Cin,
   input  logic         Op,
   output logic [N-1:0] Sum,
   output logic         Cout,
   output logic         Overflow,
   output logic         Zero,
   output logic         Negative,
   output logic         busy,
   output logic         done
);

   localparam int unsigned STEPS  = N / CHUNK;
   localparam int unsigned STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [N-1:0]      a_q, a_d;
   logic [N-1:0]      b_q, b_d;
   logic              c_q, c_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic [N-1:0]      res_q, res_d;
   logic              a_msb_q, a_msb_d;
   logic              b_msb_q, b_msb_d;
   logic [N-1:0]      sum_q, sum_d;
   logic              cout_q, cout_d;
   logic              ovf_q, ovf_d;
   logic              zero_q, zero_d;
   logic              neg_q, neg_d;

   logic [CHUNK:0]    chunk_sum;
   logic [N-1:0]      res_next;

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      c_d       = c_q;
      step_d    = step_q;
      res_d     = res_q;
      a_msb_d   = a_msb_q;
      b_msb_d   = b_msb_q;
      sum_d     = sum_q;
      cout_d    = cout_q;
      ovf_d     = ovf_q;
      zero_d    = zero_q;
      neg_d     = neg_q;

      chunk_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
                + {{CHUNK{1'b0}}, c_q};
      // New chunk enters at the top; after STEPS shifts the LSB chunk sits at bit 0.
      res_next  = N'({chunk_sum[CHUNK-1:0], res_q} >> CHUNK);

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = A;
               b_d     = Op ? ~B : B;
               c_d     = Op ? ~Cin : Cin;
               a_msb_d = A[N-1];
               b_msb_d = Op ? ~B[N-1] : B[N-1];
               step_d  = '0;
               res_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            a_d    = a_q >> CHUNK;
            b_d    = b_q >> CHUNK;
            c_d    = chunk_sum[CHUNK];
            res_d  = res_next;
            step_d = step_q + STEP_W'(1);
            if (step_q == LAST_STEP) begin
               state_d = S_DONE;
               sum_d   = res_next;
               cout_d  = chunk_sum[CHUNK];
               ovf_d   = (a_msb_q == b_msb_q) && (res_next[N-1] != a_msb_q);
               zero_d  = (res_next == '0);
               neg_d   = res_next[N-1];
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= 1'b0;
         step_q  <= '0;
         res_q   <= '0;
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
         neg_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         step_q  <= step_d;
         res_q   <= res_d;
         a_msb_q <= a_msb_d;
         b_msb_q <= b_msb_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
         neg_q   <= neg_d;
      end
   end

   assign Sum      = sum_q;
   assign Cout     = cout_q;
   assign Overflow = ovf_q;
   assign Zero     = zero_q;
   assign Negative = neg_q;
   assign busy     = (state_q != S_IDLE);
   assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub at CHUNK=2, 1 and 8 (N=8): flags, latency,
// start-while-busy, mid-run reset, plus a seeded sweep against an integer model.
module tb_serial_addsub;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] A, B;
   logic       Cin, Op;
   logic       start2, start1, start8;

   logic [7:0] s2, s1, s8;
   logic       c2, c1, c8, v2, v1, v8, z2, z1, z8, n2, n1, n8;
   logic       busy2, busy1, busy8, done2, done1, done8;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   serial_addsub #(.N(8), .CHUNK(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .A(A), .B(B), .Cin(Cin), .Op(Op),
      .Sum(s2), .Cout(c2), .Overflow(v2), .Zero(z2), .Negative(n2),
      .busy(busy2), .done(done2));

   serial_addsub #(.N(8), .CHUNK(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .A(A), .B(B), .Cin(Cin), .Op(Op),
      .Sum(s1), .Cout(c1), .Overflow(v1), .Zero(z1), .Negative(n1),
      .busy(busy1), .done(done1));

   serial_addsub #(.N(8), .CHUNK(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .A(A), .B(B), .Cin(Cin), .Op(Op),
      .Sum(s8), .Cout(c8), .Overflow(v8), .Zero(z8), .Negative(n8),
      .busy(busy8), .done(done8));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic sel_done(input int w);
      return (w == 1) ? done1 : (w == 8) ? done8 : done2;
   endfunction

   // Packed result {N,Z,C,V,Sum}
   function automatic logic [11:0] sel_res(input int w);
      if (w == 1) return {n1, z1, c1, v1, s1};
      if (w == 8) return {n8, z8, c8, v8, s8};
      return {n2, z2, c2, v2, s2};
   endfunction

   function automatic logic [11:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic cin, input logic op);
      int ia, ib, ic, sv, uv;
      logic [7:0] s;
      logic c, v;
      ia = $signed(a);
      ib = $signed(b);
      ic = cin;
      sv = op ? ia - ib - ic : ia + ib + ic;
      uv = op ? int'(a) - int'(b) - ic : int'(a) + int'(b) + ic;
      s  = uv[7:0];
      c  = op ? (uv >= 0) : (uv > 255);
      v  = (sv > 127) || (sv < -128);
      return {s[7], (s == 8'h00), c, v, s};
   endfunction

   task automatic run_op(input int w, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic op,
                         output logic [11:0] res, output int lat);
      A = a; B = b; Cin = cin; Op = op;
      start2 = (w == 2); start1 = (w == 1); start8 = (w == 8);
      @(posedge clk); #1;
      start2 = 1'b0; start1 = 1'b0; start8 = 1'b0;
      lat = 0;
      while (!sel_done(w) && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      res = sel_res(w);
      @(posedge clk); #1;
   endtask

   typedef struct {
      logic [7:0]  a, b;
      logic        cin, op;
      logic [11:0] exp;
   } vec_t;

   vec_t vecs[7];
   int   widths[3];
   int   lats[3];

   initial begin
      logic [11:0] res;
      logic [7:0]  ra, rb, held;
      logic        rc, ro;
      int          lat, bcnt, dcnt;

      // {N,Z,C,V,Sum} hand-computed
      vecs[0] = '{8'h7F, 8'h01, 1'b0, 1'b0, {4'b1001, 8'h80}};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, {4'b0110, 8'h00}};
      vecs[2] = '{8'h05, 8'h05, 1'b0, 1'b1, {4'b0110, 8'h00}};
      vecs[3] = '{8'h80, 8'h01, 1'b0, 1'b1, {4'b0011, 8'h7F}};
      vecs[4] = '{8'h12, 8'h34, 1'b1, 1'b0, {4'b0000, 8'h47}};
      vecs[5] = '{8'h01, 8'h02, 1'b0, 1'b1, {4'b1000, 8'hFF}};
      vecs[6] = '{8'h10, 8'h05, 1'b1, 1'b1, {4'b0010, 8'h0A}};
      widths  = '{2, 1, 8};
      lats    = '{4, 8, 1};

      rst_n = 1'b0; start2 = 1'b0; start1 = 1'b0; start8 = 1'b0;
      A = '0; B = '0; Cin = 1'b0; Op = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      chk("reset_c2", {busy2, done2, sel_res(2)}, 14'h0);
      chk("reset_c1", {busy1, done1, sel_res(1)}, 14'h0);
      chk("reset_c8", {busy8, done8, sel_res(8)}, 14'h0);

      foreach (widths[j]) begin
         foreach (vecs[i]) begin
            run_op(widths[j], vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].op, res, lat);
            chk($sformatf("vec%0d_c%0d", i, widths[j]), res, vecs[i].exp);
            chk($sformatf("lat%0d_c%0d", i, widths[j]), lat, lats[j]);
         end
      end

      // start held through RUN/DONE with operands changing after capture
      held = s2;
      A = 8'h10; B = 8'h20; Cin = 1'b0; Op = 1'b0; start2 = 1'b1;
      @(posedge clk); #1;
      bcnt = 0; dcnt = 0;
      for (int i = 0; i < 10; i++) begin
         if (busy2) bcnt++;
         if (i == 1) chk("hold_sum_in_run", s2, held);
         if (done2) begin
            dcnt++;
            res = sel_res(2);
            start2 = 1'b0;
         end
         A = A + 8'h11; B = B ^ 8'h5A;
         @(posedge clk); #1;
      end
      start2 = 1'b0;
      chk("held_start_busy", bcnt, 5);
      chk("held_start_done", dcnt, 1);
      chk("held_start_res", res, {4'b0000, 8'h30});

      // reset asserted for one edge while step 2 is about to run
      run_op(2, 8'h7F, 8'h01, 1'b0, 1'b0, res, lat);
      A = 8'h33; B = 8'h44; Cin = 1'b0; Op = 1'b0; start2 = 1'b1;
      @(posedge clk); #1 start2 = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      chk("abort_state", {busy2, done2, sel_res(2)}, 14'h0);
      repeat (6) @(posedge clk);
      #1 chk("abort_no_done", {busy2, done2}, 2'b00);
      run_op(2, 8'h33, 8'h44, 1'b0, 1'b0, res, lat);
      chk("after_abort_res", res, {4'b0000, 8'h77});
      chk("after_abort_lat", lat, 4);

      // seeded sweep for the bit-serial and single-step configurations
      foreach (widths[j]) begin
         if (widths[j] == 2) continue;
         for (int i = 0; i < 300; i++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            rc = 1'($urandom); ro = 1'($urandom);
            run_op(widths[j], ra, rb, rc, ro, res, lat);
            chk($sformatf("rnd_c%0d_%02h_%02h_%0d_%0d", widths[j], ra, rb, rc, ro),
                res, model(ra, rb, rc, ro));
            chk($sformatf("rnd_lat_c%0d", widths[j]), lat, lats[j]);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
